crystal_respond: RTL and testbench
==================================

# crystal_respond

Target-side emulator for the crystal-array wiring probe. It watches the eight probe lines driven by the ship-side reader. When exactly one line is held high and stable, it answers with a one-hot code on its eight return lines. The answer is chosen by a programmable 8-entry routing table. The block lets the array wiring be emulated on a second board or in closed-loop bench runs, and counts completed probe hops.

## Interface
- SETTLE_COUNT, default 16'd1000: cycles the synchronized probe value must stay constant before it is answered. Must be less than the reader's dwell time (50000).
- SYNC_STAGES, default 2: input synchronizer depth. Minimum 2.

Ports:
- system_clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- GPIO_0i  in  8  probe lines from the reader, asynchronous to system_clk
- GPIO_0o  out  8  one-hot answer lines to the reader
- cfg_we  in  1  routing-table write strobe, single cycle
- cfg_slot  in  3  table index to write
- cfg_target  in  3  answer pin for that slot
- cfg_busy  out  1  high when a write would be ignored (state not IDLE)
- fault_clr  in  1  clears the fault flag
- fault  out  1  sticky; set on a non-one-hot probe
- hop_count  out  4  completed probe/answer hops; saturates at 15

## Operation
- Reset values:
  - GPIO_0o = 0, fault = 0, hop_count = 0, cfg_busy = 0, state IDLE.
  - Routing table map[i] = (i+1) mod 8.
  - Synchronizer flops = 0.
- The FSM sees only sync_q, the last synchronizer stage, never raw GPIO_0i.
- IDLE: GPIO_0o = 0.
  - sync_q != 0 → SETTLE; latch probe = sync_q, cnt = 0.
  - cfg_we writes map[cfg_slot] = cfg_target, effective next cycle.
- SETTLE:
  - sync_q == 0 → IDLE.
  - sync_q != probe → re-latch probe, cnt = 0, stay in SETTLE.
  - Otherwise cnt++. When cnt == SETTLE_COUNT-1 → CHECK.
- CHECK (one cycle):
  - probe one-hot at bit k → DRIVE; GPIO_0o = 1 << map[k].
  - Otherwise → FAULT; fault = 1, GPIO_0o = 0.
- DRIVE: GPIO_0o is held.
  - sync_q == 0 → GPIO_0o = 0, hop_count++ (saturating), → IDLE.
  - sync_q nonzero and != probe → GPIO_0o = 0, re-latch probe, cnt = 0, → SETTLE. hop_count is not incremented.
- FAULT: GPIO_0o = 0. sync_q == 0 → IDLE.
- cfg_we outside IDLE is dropped silently. cfg_busy = (state != IDLE).
- fault_clr clears fault. If fault_clr and a set event occur in the same cycle, set wins.
- A table write takes effect only for the next probe. An answer currently on GPIO_0o never changes mid-hop.
- The routing table need not be a permutation. Duplicate targets are legal and produce the same answer.
- Asserting rst_n mid-operation returns every register to its reset value immediately. This includes the routing table.

## Timing
- All outputs are registered. GPIO_0o never glitches, and never has more than one bit set.
- Probe to answer: a probe value first captured at edge 1 appears on GPIO_0o after edge SYNC_STAGES+SETTLE_COUNT+2. With defaults this is edge 1004.
- Release: a falling probe captured at edge 1 clears GPIO_0o after edge SYNC_STAGES+1. hop_count updates on that same edge.
- cnt is 16 bits wide and never wraps, because the FSM leaves SETTLE at SETTLE_COUNT-1.
- hop_count at 15 stays at 15.

## Structure
- Shared package crystal_pkg:
  - state enum: IDLE, SETTLE, CHECK, DRIVE, FAULT.
  - constant CRYSTAL_LINES = 8.
  - onehot_idx function, returning a valid flag and a 3-bit index. Also reused by the reader.
- One sub-module: crystal_sync, a SYNC_STAGES-deep 8-bit synchronizer with asynchronous reset to 0.
- Routing table, FSM and counters live in crystal_respond.

## Test plan
Use SETTLE_COUNT=4 and SYNC_STAGES=2 throughout.
- Reset: GPIO_0i = 8'h01 held → GPIO_0o = 8'h02 after edge 8. GPIO_0i = 0 → GPIO_0o = 0 after edge 3, and hop_count = 1.
- Reprogram: in IDLE, write map[3] = 6. Drive GPIO_0i = 8'h08 → GPIO_0o = 8'h40. A write issued during DRIVE is ignored, cfg_busy = 1, and the next probe still uses the old table.
- Glitch: GPIO_0i = 8'h04 for 2 cycles, then 0 → GPIO_0o stays 0, hop_count unchanged. Switching 8'h04 to 8'h10 mid-SETTLE → answer is 8'h20 only.
- Fault: GPIO_0i = 8'h03 held → fault = 1, GPIO_0o stays 0. fault_clr pulsed together with a second 8'h03 probe reaching CHECK → fault stays 1.
- Chain: run the reader's full 8-hop sequence against the reset table → answers on pins 1, 2, …, 7, 0, and hop_count = 8. Run 20 hops → hop_count saturates at 15.
- Reset mid-operation: assert rst_n while in DRIVE → GPIO_0o = 0 and the table returns to identity+1 asynchronously.

Source files
------------

// File: rtl/crystal_pkg.sv
// Shared definitions for the crystal-array probe emulator and reader.
package crystal_pkg;

  localparam int CRYSTAL_LINES = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CHECK  = 3'd2,
    DRIVE  = 3'd3,
    FAULT  = 3'd4
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } onehot_t;

  // valid only when exactly one bit is set; idx is that bit's position
  function automatic onehot_t onehot_idx(input logic [CRYSTAL_LINES-1:0] v);
    onehot_t r;
    r.valid = (v != '0) && ((v & (v - 1'b1)) == '0);
    r.idx   = 3'd0;
    for (int i = 0; i < CRYSTAL_LINES; i++) begin
      if (v[i]) r.idx = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/crystal_sync.sv
// Multi-stage synchronizer for the asynchronous probe lines.
module crystal_sync #(
  parameter int STAGES = 2,
  parameter int W      = 8
) (
  input  logic         system_clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stg [STAGES];

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/crystal_respond.sv
// Target-side probe emulator: answers a stable one-hot probe with a
// routed one-hot return code and counts completed hops.
module crystal_respond
  import crystal_pkg::*;
#(
  parameter logic [15:0] SETTLE_COUNT = 16'd1000,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic                     system_clk,
  input  logic                     rst_n,
  input  logic [CRYSTAL_LINES-1:0] GPIO_0i,
  output logic [CRYSTAL_LINES-1:0] GPIO_0o,
  input  logic                     cfg_we,
  input  logic [2:0]               cfg_slot,
  input  logic [2:0]               cfg_target,
  output logic                     cfg_busy,
  input  logic                     fault_clr,
  output logic                     fault,
  output logic [3:0]               hop_count
);

  localparam logic [15:0] CNT_LAST = SETTLE_COUNT - 16'd1;

  state_t                     state, state_nx;
  logic [CRYSTAL_LINES-1:0]   sync_q;
  logic [CRYSTAL_LINES-1:0]   probe, probe_nx;
  logic [15:0]                cnt, cnt_nx;
  logic [CRYSTAL_LINES-1:0]   out_q, out_nx;
  logic                       fault_q;
  logic [3:0]                 hop_q;
  logic [2:0]                 map_q [CRYSTAL_LINES];
  logic                       set_fault;
  logic                       hop_inc;
  onehot_t                    oh;

  crystal_sync #(
    .STAGES (SYNC_STAGES),
    .W      (CRYSTAL_LINES)
  ) u_sync (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .d          (GPIO_0i),
    .q          (sync_q)
  );

  assign oh = onehot_idx(probe);

  always_comb begin
    state_nx  = state;
    probe_nx  = probe;
    cnt_nx    = cnt;
    out_nx    = out_q;
    set_fault = 1'b0;
    hop_inc   = 1'b0;
    case (state)
      IDLE: begin
        out_nx = '0;
        if (sync_q != '0) begin
          state_nx = SETTLE;
          probe_nx = sync_q;
          cnt_nx   = '0;
        end
      end
      SETTLE: begin
        if (sync_q == '0) begin
          state_nx = IDLE;
        end else if (sync_q != probe) begin
          probe_nx = sync_q;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = CHECK;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      CHECK: begin
        if (oh.valid) begin
          state_nx = DRIVE;
          out_nx   = CRYSTAL_LINES'(1) << map_q[oh.idx];
        end else begin
          state_nx  = FAULT;
          set_fault = 1'b1;
          out_nx    = '0;
        end
      end
      DRIVE: begin
        // answer is frozen until the probe drops or changes
        if (sync_q == '0) begin
          out_nx   = '0;
          hop_inc  = 1'b1;
          state_nx = IDLE;
        end else if (sync_q != probe) begin
          out_nx   = '0;
          probe_nx = sync_q;
          cnt_nx   = '0;
          state_nx = SETTLE;
        end
      end
      FAULT: begin
        out_nx = '0;
        if (sync_q == '0) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        out_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      probe   <= '0;
      cnt     <= '0;
      out_q   <= '0;
      fault_q <= 1'b0;
      hop_q   <= 4'd0;
      for (int i = 0; i < CRYSTAL_LINES; i++) map_q[i] <= 3'((i + 1) % CRYSTAL_LINES);
    end else begin
      state <= state_nx;
      probe <= probe_nx;
      cnt   <= cnt_nx;
      out_q <= out_nx;
      // a new fault outranks a simultaneous clear
      if (set_fault)      fault_q <= 1'b1;
      else if (fault_clr) fault_q <= 1'b0;
      if (hop_inc && hop_q != 4'hF) hop_q <= hop_q + 4'd1;
      if (state == IDLE && cfg_we) map_q[cfg_slot] <= cfg_target;
    end
  end

  assign GPIO_0o   = out_q;
  assign fault     = fault_q;
  assign hop_count = hop_q;
  assign cfg_busy  = (state != IDLE);

endmodule

// File: tb/tb_crystal_respond.sv
// Bench for crystal_respond with SETTLE_COUNT=4, SYNC_STAGES=2.
module tb_crystal_respond;

  logic       system_clk;
  logic       rst_n;
  logic [7:0] GPIO_0i;
  logic [7:0] GPIO_0o;
  logic       cfg_we;
  logic [2:0] cfg_slot;
  logic [2:0] cfg_target;
  logic       cfg_busy;
  logic       fault_clr;
  logic       fault;
  logic [3:0] hop_count;

  typedef struct {
    logic [7:0] probe;
    logic [7:0] exp_out;
    logic [3:0] exp_hop;
  } vec_t;

  vec_t       chain_tbl [20];
  logic [7:0] exp_q [$];
  int         n_vec;
  int         n_mis;

  crystal_respond #(
    .SETTLE_COUNT (16'd4),
    .SYNC_STAGES  (2)
  ) dut (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .GPIO_0i    (GPIO_0i),
    .GPIO_0o    (GPIO_0o),
    .cfg_we     (cfg_we),
    .cfg_slot   (cfg_slot),
    .cfg_target (cfg_target),
    .cfg_busy   (cfg_busy),
    .fault_clr  (fault_clr),
    .fault      (fault),
    .hop_count  (hop_count)
  );

  // clock / reset
  initial system_clk = 1'b0;
  always #5 system_clk = ~system_clk;

  task automatic tick(input int n);
    repeat (n) @(posedge system_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_mis++;
    $display("FAIL %s: no answer within cycle budget", name);
  endtask

  // wait for a nonzero answer, then compare it against the scoreboard head
  task automatic wait_answer(input string name);
    logic [7:0] got;
    logic [7:0] want;
    bit         seen;
    seen = 0;
    got  = '0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick(1);
      if (GPIO_0o != '0) begin
        seen = 1;
        got  = GPIO_0o;
      end
    end
    want = exp_q.pop_front();
    if (!seen) timeout_fail(name);
    else check(name, {24'd0, got}, {24'd0, want});
  endtask

  task automatic do_hop(input string name, input logic [7:0] pin, input logic [7:0] exp);
    exp_q.push_back(exp);
    GPIO_0i = pin;
    wait_answer(name);
    GPIO_0i = 8'h00;
    tick(3);
    check({name, "_release"}, {24'd0, GPIO_0o}, 32'h0);
  endtask

  task automatic cfg_write(input logic [2:0] slot, input logic [2:0] tgt);
    cfg_slot   = slot;
    cfg_target = tgt;
    cfg_we     = 1'b1;
    tick(1);
    cfg_we     = 1'b0;
  endtask

  initial begin
    bit saw_out;
    n_vec = 0;
    n_mis = 0;
    for (int i = 0; i < 20; i++) begin
      chain_tbl[i].probe   = 8'(1 << (i % 8));
      chain_tbl[i].exp_out = 8'(1 << ((i + 1) % 8));
      chain_tbl[i].exp_hop = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
    end

    rst_n = 1'b0; GPIO_0i = '0; cfg_we = 1'b0; cfg_slot = '0; cfg_target = '0; fault_clr = 1'b0;
    #12;
    check("reset_out",   {24'd0, GPIO_0o}, 32'h0);
    check("reset_fault", {31'd0, fault}, 32'h0);
    check("reset_hop",   {28'd0, hop_count}, 32'h0);
    check("reset_busy",  {31'd0, cfg_busy}, 32'h0);
    @(posedge system_clk); #1;
    rst_n = 1'b1;
    tick(1);

    // exact latency: probe captured at edge 1, answer after edge 8
    GPIO_0i = 8'h01;
    tick(7);
    check("lat_edge7", {24'd0, GPIO_0o}, 32'h0);
    tick(1);
    check("lat_edge8", {24'd0, GPIO_0o}, 32'h02);
    GPIO_0i = 8'h00;
    tick(2);
    check("rel_edge2", {24'd0, GPIO_0o}, 32'h02);
    tick(1);
    check("rel_edge3", {24'd0, GPIO_0o}, 32'h0);
    check("rel_hop",   {28'd0, hop_count}, 32'd1);

    // reprogram in IDLE, then attempt a write during DRIVE
    check("idle_busy", {31'd0, cfg_busy}, 32'h0);
    cfg_write(3'd3, 3'd6);
    exp_q.push_back(8'h40);
    GPIO_0i = 8'h08;
    wait_answer("reprog_answer");
    check("drive_busy", {31'd0, cfg_busy}, 32'h1);
    cfg_write(3'd3, 3'd1);
    check("drive_hold", {24'd0, GPIO_0o}, 32'h40);
    GPIO_0i = 8'h00;
    tick(3);
    check("reprog_release", {24'd0, GPIO_0o}, 32'h0);
    do_hop("ignored_write", 8'h08, 8'h40);
    check("reprog_hop", {28'd0, hop_count}, 32'd3);

    // short glitch never answered
    GPIO_0i = 8'h04;
    tick(2);
    GPIO_0i = 8'h00;
    saw_out = 0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (GPIO_0o != '0) saw_out = 1;
    end
    check("glitch_out", {31'd0, saw_out}, 32'h0);
    check("glitch_hop", {28'd0, hop_count}, 32'd3);

    // probe changes mid-settle: only the second probe is answered
    GPIO_0i = 8'h04;
    tick(4);
    exp_q.push_back(8'h20);
    GPIO_0i = 8'h10;
    wait_answer("switch_answer");
    GPIO_0i = 8'h00;
    tick(3);
    check("switch_hop", {28'd0, hop_count}, 32'd4);

    // non-one-hot probe faults
    GPIO_0i = 8'h03;
    tick(12);
    check("fault_set", {31'd0, fault}, 32'h1);
    check("fault_out", {24'd0, GPIO_0o}, 32'h0);
    GPIO_0i = 8'h00;
    tick(3);
    check("fault_sticky", {31'd0, fault}, 32'h1);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("fault_clr", {31'd0, fault}, 32'h0);
    // clear coincides with the CHECK->FAULT edge (edge 8)
    GPIO_0i = 8'h03;
    tick(7);
    check("fault_pre", {31'd0, fault}, 32'h0);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("fault_set_wins", {31'd0, fault}, 32'h1);
    GPIO_0i = 8'h00;
    tick(3);
    check("fault_hop", {28'd0, hop_count}, 32'd4);

    // asynchronous reset while driving
    exp_q.push_back(8'h40);
    GPIO_0i = 8'h08;
    wait_answer("pre_reset_answer");
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out",   {24'd0, GPIO_0o}, 32'h0);
    check("midrst_hop",   {28'd0, hop_count}, 32'h0);
    check("midrst_fault", {31'd0, fault}, 32'h0);
    check("midrst_busy",  {31'd0, cfg_busy}, 32'h0);
    GPIO_0i = 8'h00;
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // full chain against the restored reset table, running into saturation
    for (int i = 0; i < 20; i++) begin
      do_hop($sformatf("chain%0d", i), chain_tbl[i].probe, chain_tbl[i].exp_out);
      check($sformatf("chain%0d_hop", i), {28'd0, hop_count}, {28'd0, chain_tbl[i].exp_hop});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
